unigate_sweeper: RTL and testbench
==================================

Name: unigate_sweeper

Overview:
- Sequencer that exhaustively characterises one universal gate configuration in the unigate array.
- Latches a gate select, a 16-bit target truth table and an output tap. It then steps the 4-bit reference pin vector through all 16 patterns, waits a settle interval and samples the selected array output.
- Builds the captured truth table and a mismatch count against the target.
- Sits between the wishbone/LA-driven control logic and the unigate reference-mode inputs, so firmware runs one start and reads back a pass/fail result.

Parameters:
- SETTLE_CYCLES, 4, cycles the pin vector is held before sampling; legal range 1..255.
- CNT_W, 8, width of the internal settle counter; must hold SETTLE_CYCLES.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a sweep
- sel_i  in  2  gate select to apply (00 u21, 01 u31, 10 u41, 11 u22)
- func_i  in  16  target truth table; bit k is the expected output for pattern k
- out_idx_i  in  3  index of the gate_out_i bit to sample (0..5)
- gate_out_i  in  6  unigate output bus
- gate_refmode  out  1  drives the array reference-mode enable
- gate_sel  out  2  latched select to the array
- gate_func  out  16  latched truth table to the array
- gate_pin  out  4  current pattern
- busy  out  1  sweep in progress
- done  out  1  sweep finished; held until next accepted start or reset
- captured  out  16  sampled output per pattern
- mismatch_cnt  out  5  number of patterns where captured differs from func (0..16)
- pass  out  1  done and mismatch_cnt==0

Behaviour:
- Reset (wb_rst_i high at an edge): state IDLE. All outputs are 0, including gate_refmode, gate_sel, gate_func, gate_pin, busy, done, captured, mismatch_cnt and pass. The settle counter and pattern index are cleared.
- Reset has priority over everything, including mid-sweep. A sweep interrupted by reset is abandoned and leaves no partial results.
- States are IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE, start=1 at an edge:
  - Latch sel_i, func_i and out_idx_i.
  - Clear captured and mismatch_cnt; pattern=0; counter=0.
  - Set gate_refmode=1, busy=1, done=0 and go to SETTLE.
- start while busy is ignored; latched values do not change.
- SETTLE: gate_pin=pattern. The counter increments each cycle. Leave for SAMPLE at the edge where counter==SETTLE_CYCLES-1.
- SAMPLE (one cycle):
  - At its ending edge, b=gate_out_i[out_idx] is sampled and captured[pattern]<=b.
  - If b != func[pattern], mismatch_cnt increments.
  - If pattern==15: go to DONE, with busy=0, done=1 and gate_refmode=0.
  - Otherwise: pattern+1, counter=0, return to SETTLE.
- Timing: each pattern occupies SETTLE_CYCLES+1 cycles. Taking the start edge as E0, done rises at edge E0+16*(SETTLE_CYCLES+1); with the default this is E0+80.
- gate_sel and gate_func hold their latched values in DONE. gate_pin holds 15 in DONE.
- out_idx>5: the sampled bit is 0.
- pass is combinational: done & (mismatch_cnt==0).
- Results (captured, mismatch_cnt) remain stable in DONE until the next accepted start.

Optional Feature:
- Macro: UNIGATE_SWEEP_STOPFAIL_EN.
- With the macro defined:
  - A SAMPLE with a mismatch goes directly to DONE; mismatch_cnt ends at 1.
  - Extra output fail_pat (4 bits) holds the failing pattern.
  - captured bits for patterns above the failing one stay 0.
  - fail_pat resets to 0 and is 0 when the sweep passes.
- Without the macro: all 16 patterns are always swept, and the fail_pat port does not exist.

Test Plan:
- Ideal behavioural gate model; sel=10, func=16'h8000, out_idx=2, start -> done at start+80 cycles, captured=16'h8000, mismatch_cnt=0, pass=1, gate_pin walks 0..15.
- Same setup, func=16'h6996 with the model producing XOR4 -> captured=16'h6996, pass=1. Then func=16'h6996 with the model stuck at 0 -> captured=16'h0000, mismatch_cnt=8, pass=0.
- Second start pulse 10 cycles into a sweep with func=16'h0001 -> ignored; gate_func stays 16'h8000 and results match the first sweep.
- wb_rst_i for one cycle at pattern 7 -> next cycle all outputs 0 and state IDLE. A new start then gives a full 80-cycle sweep.
- SETTLE_CYCLES=1, out_idx=6 -> done at start+32, captured=16'h0000. With func=16'h00FF, mismatch_cnt=8.
- UNIGATE_SWEEP_STOPFAIL_EN with the model stuck at 0 and func=16'h0010 -> done after pattern 4 (start+5*(SETTLE_CYCLES+1)), fail_pat=4, mismatch_cnt=1, captured=16'h0000.

Source files
------------

// File: rtl/unigate_sweeper_if.sv
// rtl/unigate_sweeper_if.sv - gate-array side bundle between sweeper and unigate reference-mode inputs
//
// Signals:
//   gate_refmode  sweeper -> array  reference-mode enable
//   gate_sel      sweeper -> array  gate select (00 u21, 01 u31, 10 u41, 11 u22)
//   gate_func     sweeper -> array  truth table under test
//   gate_pin      sweeper -> array  current 4-bit reference pin pattern
//   gate_out_i    array -> sweeper  unigate output bus
// Modports: master = sweeper side, slave = array side.
interface unigate_sweeper_if;
    logic        gate_refmode;
    logic [1:0]  gate_sel;
    logic [15:0] gate_func;
    logic [3:0]  gate_pin;
    logic [5:0]  gate_out_i;

    modport master (
        output gate_refmode,
        output gate_sel,
        output gate_func,
        output gate_pin,
        input  gate_out_i
    );

    modport slave (
        input  gate_refmode,
        input  gate_sel,
        input  gate_func,
        input  gate_pin,
        output gate_out_i
    );
endinterface

// File: rtl/unigate_sweeper.sv
// rtl/unigate_sweeper.sv - exhaustive truth-table sweep of one unigate configuration
//
// Steps the reference pin vector through all 16 patterns, holds each for
// SETTLE_CYCLES cycles, samples one array output bit and builds the captured
// truth table plus a mismatch count against the target.
//
// Ports:
//   wb_clk_i       system clock
//   wb_rst_i       synchronous active-high reset
//   start          one-cycle sweep request (ignored while busy)
//   sel_i          gate select to latch
//   func_i         target truth table, bit k = expected output for pattern k
//   out_idx_i      gate_out_i bit to sample (0..5, larger values sample 0)
//   gate           unigate_sweeper_if.master (refmode/sel/func/pin out, gate_out_i in)
//   busy           sweep in progress
//   done           sweep finished, held until the next accepted start or reset
//   captured       sampled output per pattern
//   mismatch_cnt   patterns where captured differs from the target
//   pass           done with zero mismatches
//   fail_pat       first failing pattern (only with UNIGATE_SWEEP_STOPFAIL_EN)
//
// Optional feature macro: UNIGATE_SWEEP_STOPFAIL_EN - stop at the first
// mismatching pattern and report it on fail_pat.
module unigate_sweeper #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   start,
    input  logic [1:0]             sel_i,
    input  logic [15:0]            func_i,
    input  logic [2:0]             out_idx_i,
    unigate_sweeper_if.master      gate,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            captured,
    output logic [4:0]             mismatch_cnt,
    output logic                   pass
`ifdef UNIGATE_SWEEP_STOPFAIL_EN
    ,
    output logic [3:0]             fail_pat
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        pat_q, pat_d;
    logic [1:0]        sel_q, sel_d;
    logic [15:0]       func_q, func_d;
    logic [2:0]        idx_q, idx_d;
    logic [15:0]       captured_q, captured_d;
    logic [4:0]        mis_q, mis_d;
    logic              refmode_q, refmode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef UNIGATE_SWEEP_STOPFAIL_EN
    logic [3:0]        fail_q, fail_d;
`endif

    // Pad the output bus to 8 bits so indices 6 and 7 read as 0.
    logic [7:0]        out_ext;
    logic              sample_bit;
    logic              miss;
    logic              stop;

    assign out_ext    = {2'b00, gate.gate_out_i};
    assign sample_bit = out_ext[idx_q];
    assign miss       = sample_bit != func_q[pat_q];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pat_d      = pat_q;
        sel_d      = sel_q;
        func_d     = func_q;
        idx_d      = idx_q;
        captured_d = captured_q;
        mis_d      = mis_q;
        refmode_d  = refmode_q;
        busy_d     = busy_q;
        done_d     = done_q;
        stop       = 1'b0;
`ifdef UNIGATE_SWEEP_STOPFAIL_EN
        fail_d     = fail_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sel_d      = sel_i;
                    func_d     = func_i;
                    idx_d      = out_idx_i;
                    captured_d = 16'h0000;
                    mis_d      = 5'd0;
                    pat_d      = 4'd0;
                    cnt_d      = '0;
                    refmode_d  = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
`ifdef UNIGATE_SWEEP_STOPFAIL_EN
                    fail_d     = 4'd0;
`endif
                    state_d    = SETTLE;
                end
            end

            SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end

            SAMPLE: begin
                captured_d[pat_q] = sample_bit;
                if (miss) begin
                    mis_d = mis_q + 5'd1;
                end
                stop = (pat_q == 4'd15);
`ifdef UNIGATE_SWEEP_STOPFAIL_EN
                if (miss) begin
                    stop   = 1'b1;
                    fail_d = pat_q;
                end
`endif
                if (stop) begin
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    refmode_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    pat_d   = pat_q + 4'd1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pat_q      <= 4'd0;
            sel_q      <= 2'd0;
            func_q     <= 16'h0000;
            idx_q      <= 3'd0;
            captured_q <= 16'h0000;
            mis_q      <= 5'd0;
            refmode_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UNIGATE_SWEEP_STOPFAIL_EN
            fail_q     <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pat_q      <= pat_d;
            sel_q      <= sel_d;
            func_q     <= func_d;
            idx_q      <= idx_d;
            captured_q <= captured_d;
            mis_q      <= mis_d;
            refmode_q  <= refmode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UNIGATE_SWEEP_STOPFAIL_EN
            fail_q     <= fail_d;
`endif
        end
    end

    assign gate.gate_refmode = refmode_q;
    assign gate.gate_sel     = sel_q;
    assign gate.gate_func    = func_q;
    assign gate.gate_pin     = pat_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign captured          = captured_q;
    assign mismatch_cnt      = mis_q;
    assign pass              = done_q & (mis_q == 5'd0);
`ifdef UNIGATE_SWEEP_STOPFAIL_EN
    assign fail_pat          = fail_q;
`endif

endmodule

// File: tb/tb_unigate_sweeper.sv
// tb/tb_unigate_sweeper.sv - directed self-checking bench for unigate_sweeper
module tb_unigate_sweeper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // DUT 0: default SETTLE_CYCLES = 4
    logic        start0 = 1'b0;
    logic [1:0]  sel0   = 2'd0;
    logic [15:0] func0  = 16'h0000;
    logic [2:0]  idx0   = 3'd0;
    logic        busy0, done0, pass0;
    logic [15:0] cap0;
    logic [4:0]  mis0;
    logic        mode0  = 1'b1;
`ifdef UNIGATE_SWEEP_STOPFAIL_EN
    logic [3:0]  fail0;
`endif
    unigate_sweeper_if if0 ();

    // Ideal u41-style model: result on bit 2, its complement on bit 0.
    logic f0;
    assign f0 = if0.gate_func[if0.gate_pin];
    assign if0.gate_out_i = (mode0 && if0.gate_refmode) ? {3'b000, f0, 1'b0, ~f0} : 6'b000000;

    unigate_sweeper u_dut0 (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .start        (start0),
        .sel_i        (sel0),
        .func_i       (func0),
        .out_idx_i    (idx0),
        .gate         (if0),
        .busy         (busy0),
        .done         (done0),
        .captured     (cap0),
        .mismatch_cnt (mis0),
        .pass         (pass0)
`ifdef UNIGATE_SWEEP_STOPFAIL_EN
        ,
        .fail_pat     (fail0)
`endif
    );

    // DUT 1: SETTLE_CYCLES = 1, array bus held all ones
    logic        start1 = 1'b0;
    logic [1:0]  sel1   = 2'd0;
    logic [15:0] func1  = 16'h0000;
    logic [2:0]  idx1   = 3'd0;
    logic        busy1, done1, pass1;
    logic [15:0] cap1;
    logic [4:0]  mis1;
`ifdef UNIGATE_SWEEP_STOPFAIL_EN
    logic [3:0]  fail1;
`endif
    unigate_sweeper_if if1 ();
    assign if1.gate_out_i = 6'h3F;

    unigate_sweeper #(.SETTLE_CYCLES(1)) u_dut1 (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .start        (start1),
        .sel_i        (sel1),
        .func_i       (func1),
        .out_idx_i    (idx1),
        .gate         (if1),
        .busy         (busy1),
        .done         (done1),
        .captured     (cap1),
        .mismatch_cnt (mis1),
        .pass         (pass1)
`ifdef UNIGATE_SWEEP_STOPFAIL_EN
        ,
        .fail_pat     (fail1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start on DUT 0; returns 1 ns after the start edge.
    task automatic go0(input logic [1:0] s, input logic [15:0] f, input logic [2:0] ix);
        @(negedge clk);
        sel0   = s;
        func0  = f;
        idx0   = ix;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
    endtask

    // Counts edges since the start edge until done, bounded.
    task automatic wait0(input int n0, output int n);
        n = n0;
        while (!done0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic chk_zero0(input string tag);
        chk({tag, "_refmode"}, 32'(if0.gate_refmode), 32'd0);
        chk({tag, "_sel"},     32'(if0.gate_sel),     32'd0);
        chk({tag, "_func"},    32'(if0.gate_func),    32'd0);
        chk({tag, "_pin"},     32'(if0.gate_pin),     32'd0);
        chk({tag, "_busy"},    32'(busy0),            32'd0);
        chk({tag, "_done"},    32'(done0),            32'd0);
        chk({tag, "_cap"},     32'(cap0),             32'd0);
        chk({tag, "_mis"},     32'(mis0),             32'd0);
        chk({tag, "_pass"},    32'(pass0),            32'd0);
    endtask

    int n;

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero0("rst");
        chk("rst_busy1", 32'(busy1), 32'd0);
        rst = 1'b0;

        // Sweep 1: AND4 target, ideal model, pin walk and latency
        mode0 = 1'b1;
        go0(2'b10, 16'h8000, 3'd2);
        chk("s1_busy",    32'(busy0),            32'd1);
        chk("s1_refmode", 32'(if0.gate_refmode), 32'd1);
        chk("s1_sel",     32'(if0.gate_sel),     32'd2);
        chk("s1_func",    32'(if0.gate_func),    32'h8000);
        chk("s1_pin0",    32'(if0.gate_pin),     32'd0);
        repeat (36) begin @(posedge clk); #1; end
        chk("s1_pin7",    32'(if0.gate_pin),     32'd7);
        repeat (40) begin @(posedge clk); #1; end
        chk("s1_pin15",   32'(if0.gate_pin),     32'd15);
        chk("s1_nodone",  32'(done0),            32'd0);
        wait0(76, n);
        chk("s1_latency", 32'(n),                32'd80);
        chk("s1_cap",     32'(cap0),             32'h8000);
        chk("s1_mis",     32'(mis0),             32'd0);
        chk("s1_pass",    32'(pass0),            32'd1);
        chk("s1_idle",    32'(busy0),            32'd0);
        chk("s1_refoff",  32'(if0.gate_refmode), 32'd0);
        chk("s1_pinhold", 32'(if0.gate_pin),     32'd15);
        chk("s1_funchold",32'(if0.gate_func),    32'h8000);
        repeat (3) begin @(posedge clk); #1; end
        chk("s1_donehold",32'(done0),            32'd1);
        chk("s1_caphold", 32'(cap0),             32'h8000);

        // Sweep 2: XOR4 target with ideal model
        go0(2'b10, 16'h6996, 3'd2);
        chk("s2_done_clr",32'(done0),            32'd0);
        wait0(0, n);
        chk("s2_latency", 32'(n),                32'd80);
        chk("s2_cap",     32'(cap0),             32'h6996);
        chk("s2_pass",    32'(pass0),            32'd1);

        // Sweep 3: XOR4 target with model stuck at 0
        mode0 = 1'b0;
        go0(2'b10, 16'h6996, 3'd2);
        wait0(0, n);
`ifdef UNIGATE_SWEEP_STOPFAIL_EN
        chk("s3_latency", 32'(n),                32'd10);
        chk("s3_mis",     32'(mis0),             32'd1);
        chk("s3_failpat", 32'(fail0),            32'd1);
`else
        chk("s3_latency", 32'(n),                32'd80);
        chk("s3_cap",     32'(cap0),             32'h0000);
        chk("s3_mis",     32'(mis0),             32'd8);
`endif
        chk("s3_pass",    32'(pass0),            32'd0);

        // Sweep 4: start while busy is ignored
        mode0 = 1'b1;
        go0(2'b10, 16'h8000, 3'd2);
        repeat (10) begin @(posedge clk); #1; end
        @(negedge clk);
        sel0   = 2'b01;
        func0  = 16'h0001;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        chk("s4_func",    32'(if0.gate_func),    32'h8000);
        chk("s4_sel",     32'(if0.gate_sel),     32'd2);
        wait0(11, n);
        chk("s4_latency", 32'(n),                32'd80);
        chk("s4_cap",     32'(cap0),             32'h8000);
        chk("s4_mis",     32'(mis0),             32'd0);

        // Reset at pattern 7 abandons the sweep
        go0(2'b10, 16'h8000, 3'd2);
        repeat (36) begin @(posedge clk); #1; end
        chk("r_pin7",     32'(if0.gate_pin),     32'd7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_zero0("r");
        repeat (3) begin @(posedge clk); #1; end
        chk("r_stay_idle",32'(busy0),            32'd0);
        go0(2'b10, 16'h8000, 3'd2);
        wait0(0, n);
        chk("r_latency",  32'(n),                32'd80);
        chk("r_cap",      32'(cap0),             32'h8000);

        // Stop-on-fail scenario (full sweep without the feature)
        mode0 = 1'b0;
        go0(2'b10, 16'h0010, 3'd2);
        wait0(0, n);
`ifdef UNIGATE_SWEEP_STOPFAIL_EN
        chk("sf_latency", 32'(n),                32'd25);
        chk("sf_failpat", 32'(fail0),            32'd4);
`else
        chk("sf_latency", 32'(n),                32'd80);
`endif
        chk("sf_mis",     32'(mis0),             32'd1);
        chk("sf_cap",     32'(cap0),             32'h0000);
        chk("sf_pass",    32'(pass0),            32'd0);

        // DUT 1: SETTLE_CYCLES=1, out_idx=6 reads 0 despite all-ones bus
        @(negedge clk);
        sel1   = 2'b11;
        func1  = 16'h00FF;
        idx1   = 3'd6;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
`ifdef UNIGATE_SWEEP_STOPFAIL_EN
        chk("d1_latency", 32'(n),                32'd2);
        chk("d1_mis",     32'(mis1),             32'd1);
        chk("d1_failpat", 32'(fail1),            32'd0);
`else
        chk("d1_latency", 32'(n),                32'd32);
        chk("d1_mis",     32'(mis1),             32'd8);
`endif
        chk("d1_cap",     32'(cap1),             32'h0000);
        chk("d1_pass",    32'(pass1),            32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
